prog_loader: RTL
================

Name: prog_loader

Overview:
- Boot-time stage directly upstream of the stack CPU.
- Accepts the program image as a byte stream with a valid/ready handshake.
- Assembles bytes into 32-bit instruction words and writes them sequentially into the CPU instruction memory, starting at address 0.
- Holds the CPU in reset during loading and releases it when the image is complete. This replaces file-based preloading, so benches and FPGA builds can stream any program.

Parameters:
- WORD_W, 32, instruction word width; must be a multiple of 8.
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of writable words; must be <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising clk).
- in_valid  in  1  byte-stream valid.
- in_ready  out  1  byte-stream ready.
- in_data  in  8  program byte; the first byte of each word is the MSB.
- in_last  in  1  marks the final byte of the image.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  WORD_W  assembled word.
- cpu_rst  out  1  active-high reset to the CPU core.
- done  out  1  image loaded, CPU running.
- err  out  1  sticky load error.
- word_count  out  ADDR_W+1  number of words written.

Behaviour:
- Reset values (rst=0): state=LOAD, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0, word_count=0, byte index=0.
- A byte transfers when in_valid && in_ready.
- States:
  - LOAD: shift the accepted byte into the assembly register (MSB first) and increment the byte index (0..WORD_W/8-1).
    - On the byte completing a word, or on any byte with in_last=1: go to WRITE next cycle.
    - If in_last=1 arrives mid-word, the remaining low bytes are zero-padded.
  - WRITE (exactly 1 cycle): in_ready=0, mem_we=1, mem_addr=word_count, mem_wdata=assembled word. word_count increments at the end of the cycle.
    - Next state is RUN if the word carried in_last, else LOAD with the byte index cleared.
  - RUN: in_ready=0, cpu_rst=0, done=1. Terminal until rst=0.
  - ERROR: in_ready=0, cpu_rst=1, err=1, mem_we=0. Terminal until rst=0.
- Latency: the final byte of a word is accepted in cycle N; mem_we is high in cycle N+1; the next byte can be accepted in cycle N+2.
- If the last word is written in cycle N+1, then cpu_rst falls and done rises in cycle N+2.
- Overflow: if a word completes while word_count==DEPTH, enter ERROR instead of WRITE. No memory write occurs.
- in_last with zero accepted bytes in the current word (only possible after a completed word without in_last) cannot occur by protocol. in_last is sampled only on accepted bytes.
- in_valid held low: the FSM stalls in LOAD indefinitely. There is no timeout.
- Reset mid-load: all state is discarded, cpu_rst re-asserts, and memory contents are left as written (not cleared).
- Outputs are registered; there is no combinational path from in_* to mem_* or cpu_rst.
- in_ready is combinational from state only.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- When defined:
  - The word terminated by in_last is a checksum and is not written to memory.
  - The loader keeps a running sum mod 2**WORD_W of all written words.
  - The checksum-word cycle is a CHECK state: mem_we=0.
  - Match: go to RUN. Mismatch: go to ERROR.
  - word_count excludes the checksum word.
- When undefined: no CHECK state, no sum register; the last word is written as normal.

Decomposition:
- Shared package/header `cpu_defs`: WORD_W, ADDR_W, DEPTH defaults and the state encoding (LOAD=0, WRITE=1, RUN=2, ERROR=3, CHECK=4), shared with cpu and the bench.
- Natural sub-module: `byte_packer` (byte index counter, MSB-first shift, zero-pad on last, word_ready pulse).
- The FSM, address counter and checksum stay in prog_loader.

Test Plan:
- Stream 8 bytes 01 02 03 04 AA BB CC DD, in_last on DD, in_valid always high. Expect:
  - mem_we pulses with (0, 0x01020304) then (1, 0xAABBCCDD).
  - word_count=2; cpu_rst falls 1 cycle after the second write; done=1.
- Stream 6 bytes 11 22 33 44 55 66, in_last on 66 -> second word written as 0x55660000 at address 1, then RUN.
- Random in_valid gaps over a 16-word image -> identical memory contents and word_count=16; in_ready=0 only in WRITE cycles.
- DEPTH=2, stream 12 bytes with no in_last -> two writes, then err=1, cpu_rst stays 1, no third mem_we, in_ready=0.
- Assert rst=0 after 5 bytes, then release and stream 4 bytes 0A0B0C0D with in_last -> write (0, 0x0A0B0C0D); word_count=1; no residue from the aborted word.
- With PROG_LOADER_CHECKSUM_EN: words 0x00000001 and 0x00000002 plus checksum 0x00000003 -> RUN, word_count=2. Checksum 0x00000004 -> ERROR, err=1.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the stack CPU and its boot-time program loader:
// default geometry of the instruction memory and the loader state encoding.
package cpu_defs;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 256;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_WRITE = 3'd1,
        ST_RUN   = 3'd2,
        ST_ERROR = 3'd3,
        ST_CHECK = 3'd4
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles an MSB-first byte stream into WORD_W-bit words. Bytes are placed
// by lane into a cleared accumulator, so a word cut short by 'last' comes out
// with its remaining low bytes already zero. word/word_ready/word_last are
// combinational views of the byte being accepted this cycle.
module byte_packer
    import cpu_defs::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              take,
    input  logic [7:0]        data,
    input  logic              last,
    output logic [WORD_W-1:0] word,
    output logic              word_ready,
    output logic              word_last
);

    localparam int NB    = WORD_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [IDX_W-1:0]  idx_r;
    logic [WORD_W-1:0] acc_r;
    int                lane_s;

    // Merge the incoming byte into its lane and flag word completion.
    always_comb begin
        lane_s     = (NB - 1) - int'(idx_r);
        word       = acc_r | (WORD_W'(data) << (8 * lane_s));
        word_ready = take && (last || (idx_r == IDX_W'(NB - 1)));
        word_last  = take && last;
    end

    // Byte index and accumulator; both clear as soon as a word is handed off.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_r <= '0;
            acc_r <= '0;
        end else if (word_ready) begin
            idx_r <= '0;
            acc_r <= '0;
        end else if (take) begin
            idx_r <= idx_r + IDX_W'(1);
            acc_r <= word;
        end else begin
            idx_r <= idx_r;
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: streams a byte image into the CPU instruction
// memory word by word from address 0, holding the CPU in reset until the
// image is complete. Optional macro PROG_LOADER_CHECKSUM_EN treats the word
// closed by in_last as a checksum over all written words instead of code.
module prog_loader
    import cpu_defs::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    state_e            state_r, next_s;
    logic              take_s, word_ready_s, word_last_s, is_chk_s, overflow_s;
    logic [WORD_W-1:0] word_s;
    logic              last_r, mem_we_r, cpu_rst_r, done_r, err_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [WORD_W-1:0] mem_wdata_r;
    logic [ADDR_W:0]   word_count_r;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_r;
`endif

    assign in_ready   = (state_r == ST_LOAD);
    assign take_s     = in_valid && in_ready;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign done       = done_r;
    assign err        = err_r;
    assign word_count = word_count_r;

    byte_packer #(.WORD_W(WORD_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .take       (take_s),
        .data       (in_data),
        .last       (in_last),
        .word       (word_s),
        .word_ready (word_ready_s),
        .word_last  (word_last_s)
    );

    // A finished word is a checksum (never written) only when the feature is on.
    always_comb begin
`ifdef PROG_LOADER_CHECKSUM_EN
        is_chk_s = word_last_s;
`else
        is_chk_s = 1'b0;
`endif
        overflow_s = (word_count_r == (ADDR_W + 1)'(DEPTH)) && !is_chk_s;
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (!word_ready_s) begin
                    next_s = ST_LOAD;
                end else if (overflow_s) begin
                    next_s = ST_ERROR;
                end else if (is_chk_s) begin
                    next_s = ST_CHECK;
                end else begin
                    next_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_r) begin
                    next_s = ST_RUN;
                end else begin
                    next_s = ST_LOAD;
                end
            end
            ST_CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (sum_r == mem_wdata_r) begin
                    next_s = ST_RUN;
                end else begin
                    next_s = ST_ERROR;
                end
`else
                next_s = ST_ERROR;
`endif
            end
            ST_RUN:   next_s = ST_RUN;
            ST_ERROR: next_s = ST_ERROR;
            default:  next_s = ST_ERROR;
        endcase
    end

    // State register and registered outputs derived from the next state, so
    // no output has a combinational path from the byte-stream inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_LOAD;
            last_r       <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            cpu_rst_r    <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            word_count_r <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_r        <= '0;
`endif
        end else begin
            state_r   <= next_s;
            mem_we_r  <= (next_s == ST_WRITE);
            cpu_rst_r <= (next_s != ST_RUN);
            done_r    <= (next_s == ST_RUN);
            err_r     <= (next_s == ST_ERROR);
            if (word_ready_s) begin
                mem_wdata_r <= word_s;
                mem_addr_r  <= word_count_r[ADDR_W-1:0];
                last_r      <= word_last_s;
            end
            if (state_r == ST_WRITE) begin
                word_count_r <= word_count_r + (ADDR_W + 1)'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_r        <= sum_r + mem_wdata_r;
`endif
            end
        end
    end

endmodule
